// File: rtl/axis_oscilloscope_trig.sv
`default_nettype none
// ============================================================================
// Module   : axis_oscilloscope_trig
// Brief    : Multi-channel AXI-Stream capture controller. Passes the sample
//            stream through and gates m_axis_tvalid so a circular writer keeps
//            one pre/post-triggered frame. Triggers come from a level/edge
//            detector with hysteresis on any channel, an external level, or
//            an auto-mode timeout. Reports the write address of the trigger.
// Revision : 1.0 - initial release
// ============================================================================
module axis_oscilloscope_trig #(
  parameter int AXIS_TDATA_WIDTH = 32,
  parameter int CHANNELS         = 2,
  parameter int CNTR_WIDTH       = 12
) (
  input  logic                                 aclk,
  input  logic                                 aresetn,
  input  logic                                 run_flag,
  input  logic                                 stop_flag,
  input  logic                                 ext_trg_flag,
  input  logic [$clog2(CHANNELS+1)-1:0]        trg_src,
  input  logic                                 trg_edge,
  input  logic [AXIS_TDATA_WIDTH/CHANNELS-1:0] trg_level,
  input  logic [AXIS_TDATA_WIDTH/CHANNELS-1:0] trg_hyst,
  input  logic                                 auto_mode,
  input  logic [31:0]                          auto_data,
  input  logic [CNTR_WIDTH-1:0]                pre_data,
  input  logic [CNTR_WIDTH-1:0]                tot_data,
  output logic [CNTR_WIDTH+2:0]                sts_data,
  output logic                                 s_axis_tready,
  input  logic [AXIS_TDATA_WIDTH-1:0]          s_axis_tdata,
  input  logic                                 s_axis_tvalid,
  output logic [AXIS_TDATA_WIDTH-1:0]          m_axis_tdata,
  output logic                                 m_axis_tvalid
);

  localparam int SW    = AXIS_TDATA_WIDTH / CHANNELS;
  localparam int SRC_W = $clog2(CHANNELS + 1);
  // Two guard bits so level +/- hysteresis never overflows.
  localparam int CW    = SW + 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PRE  = 2'd1,
    ARM  = 2'd2,
    POST = 2'd3
  } state_t;

  state_t                 state_q, state_d;
  logic [CNTR_WIDTH-1:0]  cntr_q, cntr_d;
  logic [CNTR_WIDTH-1:0]  trg_addr_q, trg_addr_d;
  logic [CNTR_WIDTH-1:0]  post_q, post_d;
  logic                   auto_flag_q, auto_flag_d;
  logic                   done_flag_q, done_flag_d;
  logic                   armed_q, armed_d;
  logic [31:0]            timeout_q, timeout_d;
  logic                   run_q, run_d;

  logic                   busy;
  logic                   sample;
  logic                   run_rise;
  logic [CNTR_WIDTH-1:0]  cntr_nxt;
  logic [SW-1:0]          chan_x;
  logic                   chan_sel;
  logic                   is_ext;
  logic signed [CW-1:0]   x_s, level_s, hyst_s, lo_s, hi_s;
  logic                   arm_cond, fire_cond, chan_fire, real_fire, auto_fire;

  assign busy          = (state_q != IDLE);
  assign sample        = s_axis_tvalid & busy;
  assign run_rise      = run_flag & ~run_q;
  assign cntr_nxt      = (cntr_q == tot_data) ? '0 : cntr_q + CNTR_WIDTH'(1);
  assign s_axis_tready = 1'b1;
  assign m_axis_tdata  = s_axis_tdata;
  assign m_axis_tvalid = sample;
  assign sts_data      = {trg_addr_q, auto_flag_q, done_flag_q, busy};

  // Select the trigger channel sample from the packed stream word.
  always_comb begin
    chan_x = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (trg_src == SRC_W'(i)) chan_x = s_axis_tdata[i*SW +: SW];
    end
  end

  // Level/edge trigger with hysteresis, evaluated in widened signed math.
  always_comb begin
    chan_sel  = (trg_src < SRC_W'(CHANNELS));
    is_ext    = (trg_src == SRC_W'(CHANNELS));
    x_s       = {{2{chan_x[SW-1]}}, chan_x};
    level_s   = {{2{trg_level[SW-1]}}, trg_level};
    hyst_s    = {2'b00, trg_hyst};
    lo_s      = level_s - hyst_s;
    hi_s      = level_s + hyst_s;
    if (!trg_edge) begin
      arm_cond  = chan_sel & (x_s < lo_s);
      fire_cond = x_s >= level_s;
    end else begin
      arm_cond  = chan_sel & (x_s > hi_s);
      fire_cond = x_s <= level_s;
    end
    chan_fire = chan_sel & armed_q & fire_cond;
    real_fire = is_ext ? ext_trg_flag : chan_fire;
    // Counting this sample, has the timeout reached auto_data?
    auto_fire = auto_mode & (({1'b0, timeout_q} + 33'd1) >= {1'b0, auto_data});
  end

  // Capture state machine: next state and status register updates.
  always_comb begin
    state_d     = state_q;
    cntr_d      = cntr_q;
    trg_addr_d  = trg_addr_q;
    post_d      = post_q;
    auto_flag_d = auto_flag_q;
    done_flag_d = done_flag_q;
    armed_d     = armed_q;
    timeout_d   = timeout_q;
    run_d       = run_flag;

    if (stop_flag) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (run_rise) begin
            cntr_d      = '0;
            done_flag_d = 1'b0;
            auto_flag_d = 1'b0;
            armed_d     = 1'b0;
            timeout_d   = '0;
            // No pre-trigger window: skip PRE so no extra sample is forwarded.
            state_d     = (pre_data == '0) ? ARM : PRE;
          end
        end
        PRE: begin
          if (sample) begin
            cntr_d = cntr_nxt;
            if (arm_cond) armed_d = 1'b1;
            if (cntr_q == pre_data - CNTR_WIDTH'(1)) state_d = ARM;
          end
        end
        ARM: begin
          if (sample) begin
            cntr_d = cntr_nxt;
            if (auto_mode) timeout_d = timeout_q + 32'd1;
            if (chan_fire) armed_d = 1'b0;
            else if (arm_cond) armed_d = 1'b1;
            if (real_fire || auto_fire) begin
              trg_addr_d  = cntr_q;
              // Post samples remaining after this one, minus the last.
              post_d      = tot_data - pre_data - CNTR_WIDTH'(1);
              auto_flag_d = ~real_fire;
              state_d     = POST;
            end
          end
        end
        POST: begin
          if (sample) begin
            cntr_d = cntr_nxt;
            if (post_q == '0) begin
              done_flag_d = 1'b1;
              state_d     = IDLE;
            end else begin
              post_d = post_q - CNTR_WIDTH'(1);
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State and status registers with synchronous active-low reset.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_q     <= IDLE;
      cntr_q      <= '0;
      trg_addr_q  <= '0;
      post_q      <= '0;
      auto_flag_q <= 1'b0;
      done_flag_q <= 1'b0;
      armed_q     <= 1'b0;
      timeout_q   <= '0;
      run_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cntr_q      <= cntr_d;
      trg_addr_q  <= trg_addr_d;
      post_q      <= post_d;
      auto_flag_q <= auto_flag_d;
      done_flag_q <= done_flag_d;
      armed_q     <= armed_d;
      timeout_q   <= timeout_d;
      run_q       <= run_d;
    end
  end

endmodule
`default_nettype wire
